// File: rtl/register_file_windowed.sv
// Windowed SPARC integer register file: CWP-relative mapping, SAVE/RESTORE checked against WIM.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module register_file_windowed #(
    parameter int NWINDOWS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [4:0]                  Register_Dest_Sel,
    input  logic                        RF_Load,
    input  logic [WIDTH-1:0]            Write_Data,
    input  logic [4:0]                  RS1_Sel,
    input  logic [4:0]                  RS2_Sel,
    output logic [WIDTH-1:0]            RS1_Data,
    output logic [WIDTH-1:0]            RS2_Data,
    input  logic                        Save,
    input  logic                        Restore,
    input  logic                        WIM_Load,
    input  logic [NWINDOWS-1:0]         WIM_In,
    output logic [$clog2(NWINDOWS)-1:0] CWP,
    output logic [NWINDOWS-1:0]         WIM,
    output logic                        Window_Overflow,
    output logic                        Window_Underflow
);

    localparam int CW   = $clog2(NWINDOWS);
    localparam int PHYS = 8 + 16 * NWINDOWS;
    localparam int PW   = CW + 5;

    logic [WIDTH-1:0]    rf_q [PHYS];
    logic [CW-1:0]       cwp_q, cwp_d;
    logic [NWINDOWS-1:0] wim_q, wim_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;

    // Window offset wraps modulo 16*NWINDOWS, i.e. the low CW+4 bits, so the
    // ins of the last window land on the outs of window 0.
    function automatic logic [PW-1:0] phys_idx(input logic [4:0] r, input logic [CW-1:0] w);
        logic [CW+3:0] off;
        if (r < 5'd8) return PW'(r[2:0]);
        off = {w, 4'b0000} + (CW+4)'(r - 5'd8);
        return {1'b0, off} + PW'(8);
    endfunction

    logic [CW-1:0] save_nxt, rest_nxt;
    logic          save_req, rest_req;

    assign save_nxt = cwp_q - CW'(1);
    assign rest_nxt = cwp_q + CW'(1);
    assign save_req = Save & ~Restore;
    assign rest_req = Restore & ~Save;

    always_comb begin
        cwp_d = cwp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        wim_d = WIM_Load ? WIM_In : wim_q;
        // Moves are judged against the WIM in effect before this edge.
        if (save_req) begin
            if (wim_q[save_nxt]) ovf_d = 1'b1;
            else                 cwp_d = save_nxt;
        end else if (rest_req) begin
            if (wim_q[rest_nxt]) unf_d = 1'b1;
            else                 cwp_d = rest_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cwp_q <= '0;
            wim_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cwp_q <= cwp_d;
            wim_q <= wim_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < PHYS; i++) rf_q[i] <= '0;
        end else if (RF_Load && Register_Dest_Sel != 5'd0) begin
            rf_q[phys_idx(Register_Dest_Sel, cwp_q)] <= Write_Data;
        end
    end

    logic [WIDTH-1:0] rd1, rd2;

    assign rd1 = (RS1_Sel == 5'd0) ? '0 : rf_q[phys_idx(RS1_Sel, cwp_q)];
    assign rd2 = (RS2_Sel == 5'd0) ? '0 : rf_q[phys_idx(RS2_Sel, cwp_q)];

`ifdef RF_BYPASS_EN
    logic byp_ok;
    assign byp_ok   = RF_Load & ~Save & ~Restore & (Register_Dest_Sel != 5'd0);
    assign RS1_Data = (byp_ok && RS1_Sel == Register_Dest_Sel) ? Write_Data : rd1;
    assign RS2_Data = (byp_ok && RS2_Sel == Register_Dest_Sel) ? Write_Data : rd2;
`else
    assign RS1_Data = rd1;
    assign RS2_Data = rd2;
`endif

    assign CWP              = cwp_q;
    assign WIM              = wim_q;
    assign Window_Overflow  = ovf_q;
    assign Window_Underflow = unf_q;

endmodule

// File: tb/tb_register_file_windowed.sv
// Bench for register_file_windowed: directed plan steps then random traffic vs an array model.
// Build with RF_BYPASS_EN defined to check the forwarding variant.
module tb_register_file_windowed;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = $clog2(N);
    localparam int PH = 8 + 16 * N;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [4:0]    Register_Dest_Sel, RS1_Sel, RS2_Sel;
    logic          RF_Load, Save, Restore, WIM_Load;
    logic [W-1:0]  Write_Data, RS1_Data, RS2_Data;
    logic [N-1:0]  WIM_In, WIM;
    logic [CW-1:0] CWP;
    logic          Window_Overflow, Window_Underflow;

    always #5 Clk = ~Clk;

    register_file_windowed #(.NWINDOWS(N), .WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Register_Dest_Sel(Register_Dest_Sel), .RF_Load(RF_Load),
        .Write_Data(Write_Data), .RS1_Sel(RS1_Sel), .RS2_Sel(RS2_Sel), .RS1_Data(RS1_Data),
        .RS2_Data(RS2_Data), .Save(Save), .Restore(Restore), .WIM_Load(WIM_Load),
        .WIM_In(WIM_In), .CWP(CWP), .WIM(WIM), .Window_Overflow(Window_Overflow),
        .Window_Underflow(Window_Underflow)
    );

    int n_chk = 0, n_fail = 0;

    // Reference model: physical array plus architectural state
    logic [W-1:0] mem [PH];
    int           mcwp;
    logic [N-1:0] mwim;
    logic         mov, mun;
    bit           mvalid = 0;

    function automatic int map_reg(int r, int c);
        if (r < 8) return r;
        return 8 + ((c * 16 + r - 8) % (16 * N));
    endfunction

    function automatic logic [W-1:0] mread(int r);
        if (r == 0) return '0;
        return mem[map_reg(r, mcwp)];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        Reset = 0; RF_Load = 0; Save = 0; Restore = 0; WIM_Load = 0;
        Register_Dest_Sel = 0; Write_Data = 0; WIM_In = 0; RS1_Sel = 0; RS2_Sel = 0;
    endtask

    function automatic logic [W-1:0] exp_read(logic [4:0] sel);
        logic [W-1:0] e;
        e = mread(int'(sel));
`ifdef RF_BYPASS_EN
        if (RF_Load && !Save && !Restore && sel != 0 && sel == Register_Dest_Sel) e = Write_Data;
`endif
        return e;
    endfunction

    // Check reads before the edge, advance the model on the edge, check state after it.
    task automatic cycle();
        int nxt;
        #1;
        if (mvalid && !Reset) begin
            chk("rs1", RS1_Data, exp_read(RS1_Sel));
            chk("rs2", RS2_Data, exp_read(RS2_Sel));
        end
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < PH; i++) mem[i] = '0;
            mcwp = 0; mwim = '0; mov = 0; mun = 0; mvalid = 1;
        end else begin
            if (RF_Load && Register_Dest_Sel != 0) mem[map_reg(Register_Dest_Sel, mcwp)] = Write_Data;
            mov = 0; mun = 0;
            if (Save && !Restore) begin
                nxt = (mcwp + N - 1) % N;
                if (mwim[nxt]) mov = 1; else mcwp = nxt;
            end else if (Restore && !Save) begin
                nxt = (mcwp + 1) % N;
                if (mwim[nxt]) mun = 1; else mcwp = nxt;
            end
            if (WIM_Load) mwim = WIM_In;
        end
        #1;
        chk("cwp", W'(CWP), W'(mcwp));
        chk("wim", W'(WIM), W'(mwim));
        chk("ovf", W'(Window_Overflow), W'(mov));
        chk("unf", W'(Window_Underflow), W'(mun));
    endtask

    task automatic wr(input logic [4:0] r, input logic [W-1:0] d);
        idle(); RF_Load = 1; Register_Dest_Sel = r; Write_Data = d; cycle();
    endtask

    task automatic peek(input string tag, input logic [4:0] r, input logic [W-1:0] exp);
        idle(); RS1_Sel = r; #1; chk(tag, RS1_Data, exp);
    endtask

    initial begin
        idle(); Reset = 1;
        cycle(); cycle();
        chk("rst_cwp", W'(CWP), '0);
        chk("rst_ovf", W'(Window_Overflow), '0);

        wr(5'd15, 32'h0000_1234);
        peek("t1_r15", 5'd15, 32'h0000_1234);
        RS2_Sel = 0; #1; chk("t1_r0", RS2_Data, '0);
        cycle();

        wr(5'd0, 32'hFFFF_FFFF);
        peek("t2_r0", 5'd0, '0);

        wr(5'd15, 32'hAAAA_0001);
        idle(); Save = 1; cycle();
        chk("t3_cwp_save", W'(CWP), 32'd3);
        peek("t3_r31", 5'd31, 32'hAAAA_0001);
        idle(); Restore = 1; cycle();
        chk("t3_cwp_rest", W'(CWP), 32'd0);
        peek("t3_r15", 5'd15, 32'hAAAA_0001);

        wr(5'd17, 32'h55);
        wr(5'd1, 32'h77);
        idle(); Restore = 1; cycle();
        wr(5'd17, 32'h66);
        peek("t4_r17_w1", 5'd17, 32'h66);
        peek("t4_r1_w1", 5'd1, 32'h77);
        idle(); Save = 1; cycle();
        peek("t4_r17_w0", 5'd17, 32'h55);
        peek("t4_r1_w0", 5'd1, 32'h77);

        idle(); WIM_Load = 1; WIM_In = 4'b1000; cycle();
        idle(); Save = 1; cycle();
        chk("t5_ovf", W'(Window_Overflow), 32'd1);
        chk("t5_cwp", W'(CWP), 32'd0);
        idle(); cycle();
        chk("t5_ovf_clr", W'(Window_Overflow), 32'd0);
        idle(); WIM_Load = 1; WIM_In = 4'b0010; cycle();
        idle(); Restore = 1; cycle();
        chk("t5_unf", W'(Window_Underflow), 32'd1);
        idle(); Save = 1; Restore = 1; cycle();
        chk("t5_both_cwp", W'(CWP), 32'd0);
        chk("t5_both_unf", W'(Window_Underflow), 32'd0);

        wr(5'd18, 32'h1111);
        idle(); RF_Load = 1; Register_Dest_Sel = 18; Write_Data = 32'hBEEF; RS2_Sel = 18; #1;
`ifdef RF_BYPASS_EN
        chk("t6_byp", RS2_Data, 32'hBEEF);
`else
        chk("t6_nobyp", RS2_Data, 32'h1111);
`endif
        cycle();
        idle(); RS2_Sel = 18; #1; chk("t6_after", RS2_Data, 32'hBEEF);
        cycle();

        idle(); WIM_Load = 1; WIM_In = '0; cycle();
        for (int i = 0; i < 3000; i++) begin
            idle();
            Reset             = ($urandom_range(0, 199) == 0);
            RF_Load           = $urandom_range(0, 1);
            Register_Dest_Sel = 5'($urandom_range(0, 31));
            Write_Data        = $urandom;
            RS1_Sel           = ($urandom_range(0, 3) == 0) ? Register_Dest_Sel : 5'($urandom_range(0, 31));
            RS2_Sel           = 5'($urandom_range(0, 31));
            Save              = ($urandom_range(0, 7) == 0);
            Restore           = ($urandom_range(0, 7) == 0);
            WIM_Load          = ($urandom_range(0, 19) == 0);
            WIM_In            = N'($urandom & $urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
